// File: rtl/avalon_dvp_vo_pkg.sv
// Shared definitions for the DVP raw video output port: register map,
// interrupt bit positions, control state encoding and register helpers.
package avalon_dvp_vo_pkg;

    // Avalon-MM register map (word addresses)
    localparam logic [5:0] ADDR_ENABLE        = 6'd0;
    localparam logic [5:0] ADDR_WIDTH         = 6'd1;
    localparam logic [5:0] ADDR_HEIGHT        = 6'd2;
    localparam logic [5:0] ADDR_FRAME_CNT     = 6'd3;
    localparam logic [5:0] ADDR_UNDERFLOW_CNT = 6'd4;
    localparam logic [5:0] ADDR_INT_STATUS    = 6'd5;
    localparam logic [5:0] ADDR_INT_MASK      = 6'd6;

    // INT_STATUS / INT_MASK bit positions
    localparam int unsigned INT_FRAME_START = 0;
    localparam int unsigned INT_UNDERFLOW   = 1;

    // Pixel path control states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_RUN  = 2'd2
    } vo_state_e;

    // WIDTH/HEIGHT keep the low 16 bits; a zero dimension is stored as 1
    function automatic logic [15:0] dim_from_write(input logic [31:0] wdata);
        dim_from_write = (wdata[15:0] == 16'd0) ? 16'd1 : wdata[15:0];
    endfunction

endpackage

// File: rtl/avalon_dvp_vo_timing.sv
// Frame timing generator: h/v counters, shadowed frame geometry and the
// active / vsync / frame-wrap decode used by the DVP output control.
module dvp_out_timing
    import avalon_dvp_vo_pkg::*;
#(
    parameter logic [15:0] H_FRONT = 16'd200,
    parameter logic [15:0] H_PULSE = 16'd536,
    parameter logic [15:0] H_BACK  = 16'd200,
    parameter logic [15:0] V_FRONT = 16'd100,
    parameter logic [15:0] V_PULSE = 16'd240,
    parameter logic [15:0] V_BACK  = 16'd100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en_i,
    input  logic [15:0] width_i,
    input  logic [15:0] height_i,
    output logic        active_o,
    output logic        vs_o,
    output logic        frame_wrap_o
);

    localparam logic [15:0] H_BLANK = H_FRONT + H_PULSE + H_BACK;
    localparam logic [15:0] V_BLANK = V_FRONT + V_PULSE + V_BACK;
    localparam logic [15:0] VS_END  = V_FRONT + V_PULSE;

    logic [15:0] h_q, h_d;
    logic [15:0] v_q, v_d;
    logic [15:0] width_sh_q, width_sh_d;
    logic [15:0] height_sh_q, height_sh_d;
    logic [15:0] h_last, v_last;
    logic        h_end, v_end;

    assign h_last = H_BLANK + width_sh_q - 16'd1;
    assign v_last = V_BLANK + height_sh_q - 16'd1;
    assign h_end  = (h_q == h_last);
    assign v_end  = (v_q == v_last);

    // Counter advance; shadows track the registers while disabled so that
    // the value present at the 0->1 enable edge is the one captured
    always_comb begin
        h_d         = h_q;
        v_d         = v_q;
        width_sh_d  = width_sh_q;
        height_sh_d = height_sh_q;
        if (!en_i) begin
            h_d         = '0;
            v_d         = '0;
            width_sh_d  = width_i;
            height_sh_d = height_i;
        end else if (h_end) begin
            h_d = '0;
            if (v_end) begin
                v_d         = '0;
                width_sh_d  = width_i;
                height_sh_d = height_i;
            end else begin
                v_d = v_q + 16'd1;
            end
        end else begin
            h_d = h_q + 16'd1;
        end
    end

    // Counter and shadow registers
    always_ff @(posedge clk) begin
        if (reset) begin
            h_q         <= '0;
            v_q         <= '0;
            width_sh_q  <= '0;
            height_sh_q <= '0;
        end else begin
            h_q         <= h_d;
            v_q         <= v_d;
            width_sh_q  <= width_sh_d;
            height_sh_q <= height_sh_d;
        end
    end

    assign active_o     = en_i & (h_q >= H_BLANK) & (v_q >= V_BLANK);
    assign vs_o         = en_i & (v_q >= V_FRONT) & (v_q < VS_END);
    assign frame_wrap_o = en_i & h_end & v_end;

endmodule

// File: rtl/avalon_dvp_vo.sv
// DVP raw video output port: Avalon-MM register file, SOP-aligned pixel
// sink control (IDLE/SYNC/RUN) and registered DVP output pins.
module avalon_dvp_vo
    import avalon_dvp_vo_pkg::*;
#(
    parameter int          BITS       = 8,
    parameter logic [15:0] H_FRONT    = 16'd200,
    parameter logic [15:0] H_PULSE    = 16'd536,
    parameter logic [15:0] H_BACK     = 16'd200,
    parameter logic [15:0] V_FRONT    = 16'd100,
    parameter logic [15:0] V_PULSE    = 16'd240,
    parameter logic [15:0] V_BACK     = 16'd100,
    parameter logic [15:0] H_DISP_RST = 16'd960,
    parameter logic [15:0] V_DISP_RST = 16'd544
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [5:0]      as_address,
    input  logic            as_read,
    output logic [31:0]     as_readdata,
    input  logic            as_write,
    input  logic [31:0]     as_writedata,
    output logic            as_irq,
    input  logic [BITS-1:0] st_data,
    input  logic            st_valid,
    input  logic            st_sop,
    output logic            st_ready,
    output logic            out_pclk,
    output logic            out_href,
    output logic            out_vsync,
    output logic [BITS-1:0] out_raw
);

    vo_state_e       state_q;
    logic            enable_q, enable_d;
    logic [15:0]     width_q, width_d;
    logic [15:0]     height_q, height_d;
    logic [31:0]     frame_cnt_q, frame_cnt_d;
    logic [31:0]     underflow_cnt_q, underflow_cnt_d;
    logic [1:0]      int_status_q, int_status_d;
    logic [1:0]      int_mask_q, int_mask_d;
    logic [31:0]     readdata_q, readdata_d;
    logic [31:0]     rd_mux;
    logic            missed_q;
    logic            vs_prev_q;
    logic            href_q, vsync_q;
    logic [BITS-1:0] raw_q;

    logic active, vs, frame_wrap;
    logic wr_en, sop_head, start, take_run, accept_px, drop_px, underflow, vs_rise;

    dvp_out_timing #(
        .H_FRONT(H_FRONT),
        .H_PULSE(H_PULSE),
        .H_BACK (H_BACK),
        .V_FRONT(V_FRONT),
        .V_PULSE(V_PULSE),
        .V_BACK (V_BACK)
    ) u_timing (
        .clk         (clk),
        .reset       (reset),
        .en_i        (enable_q),
        .width_i     (width_q),
        .height_i    (height_q),
        .active_o    (active),
        .vs_o        (vs),
        .frame_wrap_o(frame_wrap)
    );

    // A read in the same cycle suppresses the write
    assign wr_en = as_write & ~as_read;

    // Pixel acceptance: a frame may only start on an SOP at its first active
    // pixel; once that chance is missed the frame is blanked until the wrap
    assign sop_head  = st_valid & st_sop;
    assign start     = (state_q == ST_SYNC) & ~missed_q & active & sop_head;
    assign take_run  = (state_q == ST_RUN) & active & st_valid;
    assign accept_px = start | take_run;
    assign drop_px   = (state_q == ST_SYNC) & ~active & st_valid & ~st_sop;
    assign underflow = active & ~accept_px;
    assign vs_rise   = vs & ~vs_prev_q;

    // Sink handshake
    always_comb begin
        st_ready = 1'b0;
        unique case (state_q)
            ST_SYNC: st_ready = start | drop_px;
            ST_RUN:  st_ready = active;
            default: st_ready = 1'b0;
        endcase
    end

    // Register writes and event counters
    always_comb begin
        enable_d        = enable_q;
        width_d         = width_q;
        height_d        = height_q;
        int_mask_d      = int_mask_q;
        int_status_d    = int_status_q;
        frame_cnt_d     = frame_cnt_q + {31'd0, vs_rise};
        underflow_cnt_d = underflow_cnt_q + {31'd0, underflow};
        if (wr_en) begin
            case (as_address)
                ADDR_ENABLE:     enable_d     = as_writedata[0];
                ADDR_WIDTH:      width_d      = dim_from_write(as_writedata);
                ADDR_HEIGHT:     height_d     = dim_from_write(as_writedata);
                ADDR_INT_STATUS: int_status_d = '0;
                ADDR_INT_MASK:   int_mask_d   = as_writedata[1:0];
                default: ;
            endcase
        end
        // Event sets take precedence over a clearing write in the same cycle
        if (vs_rise)   int_status_d[INT_FRAME_START] = 1'b1;
        if (underflow) int_status_d[INT_UNDERFLOW]   = 1'b1;
    end

    // Read data mux
    always_comb begin
        rd_mux = '0;
        case (as_address)
            ADDR_ENABLE:        rd_mux = {31'd0, enable_q};
            ADDR_WIDTH:         rd_mux = {16'd0, width_q};
            ADDR_HEIGHT:        rd_mux = {16'd0, height_q};
            ADDR_FRAME_CNT:     rd_mux = frame_cnt_q;
            ADDR_UNDERFLOW_CNT: rd_mux = underflow_cnt_q;
            ADDR_INT_STATUS:    rd_mux = {30'd0, int_status_q};
            ADDR_INT_MASK:      rd_mux = {30'd0, int_mask_q};
            default:            rd_mux = '0;
        endcase
        readdata_d = as_read ? rd_mux : readdata_q;
    end

    // Register file, counters and read data register
    always_ff @(posedge clk) begin
        if (reset) begin
            enable_q        <= 1'b0;
            width_q         <= H_DISP_RST;
            height_q        <= V_DISP_RST;
            frame_cnt_q     <= '0;
            underflow_cnt_q <= '0;
            int_status_q    <= '0;
            int_mask_q      <= 2'b11;
            readdata_q      <= '0;
            vs_prev_q       <= 1'b0;
        end else begin
            enable_q        <= enable_d;
            width_q         <= width_d;
            height_q        <= height_d;
            frame_cnt_q     <= frame_cnt_d;
            underflow_cnt_q <= underflow_cnt_d;
            int_status_q    <= int_status_d;
            int_mask_q      <= int_mask_d;
            readdata_q      <= readdata_d;
            vs_prev_q       <= vs;
        end
    end

    // Control FSM and DVP output registers; keyed on the next ENABLE value
    // so a disabling write blanks the pins on the very next cycle
    always_ff @(posedge clk) begin
        if (reset || !enable_d) begin
            state_q  <= ST_IDLE;
            missed_q <= 1'b0;
            href_q   <= 1'b0;
            vsync_q  <= 1'b0;
            raw_q    <= '0;
        end else begin
            href_q  <= active;
            vsync_q <= vs;
            raw_q   <= accept_px ? st_data : '0;
            unique case (state_q)
                ST_IDLE: begin
                    state_q  <= ST_SYNC;
                    missed_q <= 1'b0;
                end
                ST_SYNC: begin
                    if (frame_wrap) begin
                        missed_q <= 1'b0;
                    end else if (start) begin
                        state_q <= ST_RUN;
                    end else if (underflow) begin
                        missed_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (frame_wrap) state_q <= ST_SYNC;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign as_readdata = readdata_q;
    assign as_irq      = |(int_status_q & ~int_mask_q);
    assign out_pclk    = ~clk;
    assign out_href    = href_q;
    assign out_vsync   = vsync_q;
    assign out_raw     = raw_q;

endmodule

// File: tb/tb_avalon_dvp_vo.sv
// Directed testbench for avalon_dvp_vo using a small frame geometry:
// 10 clocks per line, 5 lines per frame, active pixels at h 6..9 of lines 3..4.
module tb_avalon_dvp_vo;

    localparam logic [5:0] A_ENABLE = 6'd0;
    localparam logic [5:0] A_WIDTH  = 6'd1;
    localparam logic [5:0] A_HEIGHT = 6'd2;
    localparam logic [5:0] A_FRAME  = 6'd3;
    localparam logic [5:0] A_UNDER  = 6'd4;
    localparam logic [5:0] A_STATUS = 6'd5;
    localparam logic [5:0] A_MASK   = 6'd6;

    typedef struct {
        logic [7:0] d;
        logic       s;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  as_address = '0;
    logic        as_read = 1'b0;
    logic [31:0] as_readdata;
    logic        as_write = 1'b0;
    logic [31:0] as_writedata = '0;
    logic        as_irq;
    logic [7:0]  st_data = '0;
    logic        st_valid = 1'b0;
    logic        st_sop = 1'b0;
    logic        st_ready;
    logic        out_pclk, out_href, out_vsync;
    logic [7:0]  out_raw;

    int    checks = 0;
    int    errors = 0;
    beat_t bq[$];
    logic  last_acc;

    avalon_dvp_vo #(
        .BITS      (8),
        .H_FRONT   (16'd2),
        .H_PULSE   (16'd2),
        .H_BACK    (16'd2),
        .V_FRONT   (16'd1),
        .V_PULSE   (16'd1),
        .V_BACK    (16'd1),
        .H_DISP_RST(16'd4),
        .V_DISP_RST(16'd2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .as_address  (as_address),
        .as_read     (as_read),
        .as_readdata (as_readdata),
        .as_write    (as_write),
        .as_writedata(as_writedata),
        .as_irq      (as_irq),
        .st_data     (st_data),
        .st_valid    (st_valid),
        .st_sop      (st_sop),
        .st_ready    (st_ready),
        .out_pclk    (out_pclk),
        .out_href    (out_href),
        .out_vsync   (out_vsync),
        .out_raw     (out_raw)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        as_read = 1'b0;
        as_write = 1'b0;
        st_valid = 1'b0;
        st_sop = 1'b0;
        bq.delete();
        repeat (2) tick();
        reset = 1'b0;
    endtask

    task automatic bus_write(input logic [5:0] addr, input logic [31:0] data);
        as_address = addr;
        as_writedata = data;
        as_write = 1'b1;
        tick();
        as_write = 1'b0;
    endtask

    task automatic bus_read(input logic [5:0] addr, output logic [31:0] data);
        as_address = addr;
        as_read = 1'b1;
        tick();
        as_read = 1'b0;
        data = as_readdata;
    endtask

    task automatic push_beats(input logic [7:0] base, input int n, input logic first_sop);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.d = base + 8'(i);
            b.s = (i == 0) ? first_sop : 1'b0;
            bq.push_back(b);
        end
    endtask

    // One pixel clock: present the queue head (if allowed), note acceptance
    task automatic step(input logic allow);
        st_valid = allow && (bq.size() > 0);
        st_data  = st_valid ? bq[0].d : 8'h00;
        st_sop   = st_valid ? bq[0].s : 1'b0;
        #1;
        last_acc = st_valid & st_ready;
        @(posedge clk);
        #1;
        if (last_acc) bq.delete(0);
        st_valid = 1'b0;
        st_sop = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic [31:0] exp_regs [7];
        exp_regs = '{32'd0, 32'd4, 32'd2, 32'd0, 32'd0, 32'd0, 32'd3};
        apply_reset();
        checks++; if (as_readdata !== 32'd0) begin errors++; $display("FAIL reset_readdata got %0h exp 0", as_readdata); end
        checks++; if (out_href !== 1'b0 || out_vsync !== 1'b0 || out_raw !== 8'h00) begin errors++; $display("FAIL reset_outputs got href=%0b vs=%0b raw=%0h exp 0", out_href, out_vsync, out_raw); end
        checks++; if (as_irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %0b exp 0", as_irq); end
        st_valid = 1'b1; st_sop = 1'b0; #1;
        checks++; if (st_ready !== 1'b0) begin errors++; $display("FAIL reset_st_ready got %0b exp 0", st_ready); end
        st_valid = 1'b0;
        for (int a = 0; a < 7; a++) begin
            bus_read(6'(a), rd);
            checks++; if (rd !== exp_regs[a]) begin errors++; $display("FAIL reset_reg%0d got %0h exp %0h", a, rd, exp_regs[a]); end
        end
    endtask

    task automatic test_registers();
        logic [31:0] rd;
        apply_reset();
        bus_write(A_WIDTH, 32'd0);
        bus_read(A_WIDTH, rd);
        checks++; if (rd !== 32'd1) begin errors++; $display("FAIL reg_width_zero got %0h exp 1", rd); end
        bus_write(A_WIDTH, 32'h0001_0007);
        bus_read(A_WIDTH, rd);
        checks++; if (rd !== 32'd7) begin errors++; $display("FAIL reg_width_trunc got %0h exp 7", rd); end
        bus_read(6'd63, rd);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL reg_unmapped got %0h exp 0", rd); end
        as_address = A_HEIGHT; as_writedata = 32'd9; as_read = 1'b1; as_write = 1'b1;
        tick();
        as_read = 1'b0; as_write = 1'b0;
        checks++; if (as_readdata !== 32'd2) begin errors++; $display("FAIL reg_rw_collide_read got %0h exp 2", as_readdata); end
        bus_read(A_HEIGHT, rd);
        checks++; if (rd !== 32'd2) begin errors++; $display("FAIL reg_rw_collide_nowrite got %0h exp 2", rd); end
        bus_write(A_FRAME, 32'd5);
        bus_read(A_FRAME, rd);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL reg_ro_write got %0h exp 0", rd); end
        bus_write(A_MASK, 32'hFFFF_FFFD);
        bus_read(A_MASK, rd);
        checks++; if (rd !== 32'd1) begin errors++; $display("FAIL reg_mask got %0h exp 1", rd); end
    endtask

    task automatic test_nominal();
        logic [7:0]  pix;
        logic        e_href, e_vs;
        logic [31:0] rd;
        apply_reset();
        push_beats(8'h10, 8, 1'b1);
        bus_write(A_ENABLE, 32'd1);
        pix = 8'h10;
        for (int k = 0; k < 50; k++) begin
            step(1'b1);
            e_href = ((k % 10) >= 6) && ((k / 10) >= 3);
            e_vs   = ((k / 10) == 1);
            checks++; if (out_href !== e_href) begin errors++; $display("FAIL nominal_href k=%0d got %0b exp %0b", k, out_href, e_href); end
            checks++; if (out_vsync !== e_vs) begin errors++; $display("FAIL nominal_vsync k=%0d got %0b exp %0b", k, out_vsync, e_vs); end
            checks++; if (out_raw !== (e_href ? pix : 8'h00)) begin errors++; $display("FAIL nominal_raw k=%0d got %0h exp %0h", k, out_raw, e_href ? pix : 8'h00); end
            if (e_href) pix = pix + 8'd1;
        end
        bus_read(A_FRAME, rd);
        checks++; if (rd !== 32'd1) begin errors++; $display("FAIL nominal_frame_cnt got %0d exp 1", rd); end
        bus_read(A_STATUS, rd);
        checks++; if (rd !== 32'd1) begin errors++; $display("FAIL nominal_int_status got %0h exp 1", rd); end
        bus_read(A_UNDER, rd);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL nominal_underflow got %0d exp 0", rd); end
    endtask

    task automatic test_underflow();
        logic [7:0]  pix;
        logic        e_href, gap;
        logic [7:0]  e_raw;
        logic [31:0] rd;
        apply_reset();
        bus_write(A_MASK, 32'd1);
        push_beats(8'h20, 8, 1'b1);
        bus_write(A_ENABLE, 32'd1);
        pix = 8'h20;
        for (int k = 0; k < 50; k++) begin
            gap = (k == 37) || (k == 38);
            step(!gap);
            e_href = ((k % 10) >= 6) && ((k / 10) >= 3);
            e_raw  = (e_href && !gap) ? pix : 8'h00;
            checks++; if (out_href !== e_href) begin errors++; $display("FAIL underflow_href k=%0d got %0b exp %0b", k, out_href, e_href); end
            checks++; if (out_raw !== e_raw) begin errors++; $display("FAIL underflow_raw k=%0d got %0h exp %0h", k, out_raw, e_raw); end
            if (e_href && !gap) pix = pix + 8'd1;
        end
        bus_read(A_UNDER, rd);
        checks++; if (rd !== 32'd2) begin errors++; $display("FAIL underflow_cnt got %0d exp 2", rd); end
        bus_read(A_STATUS, rd);
        checks++; if (rd !== 32'd3) begin errors++; $display("FAIL underflow_status got %0h exp 3", rd); end
        checks++; if (as_irq !== 1'b1) begin errors++; $display("FAIL underflow_irq got %0b exp 1", as_irq); end
        bus_write(A_STATUS, 32'd0);
        bus_read(A_STATUS, rd);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL underflow_status_clear got %0h exp 0", rd); end
        checks++; if (as_irq !== 1'b0) begin errors++; $display("FAIL underflow_irq_clear got %0b exp 0", as_irq); end
    endtask

    task automatic test_sop_align();
        logic [7:0] pix;
        logic       e_href, e_acc;
        apply_reset();
        push_beats(8'h31, 3, 1'b0);
        push_beats(8'h40, 8, 1'b1);
        bus_write(A_ENABLE, 32'd1);
        pix = 8'h40;
        for (int k = 0; k < 50; k++) begin
            step(1'b1);
            e_href = ((k % 10) >= 6) && ((k / 10) >= 3);
            e_acc  = (k < 3) || e_href;
            checks++; if (last_acc !== e_acc) begin errors++; $display("FAIL sop_accept k=%0d got %0b exp %0b", k, last_acc, e_acc); end
            checks++; if (out_raw !== (e_href ? pix : 8'h00)) begin errors++; $display("FAIL sop_raw k=%0d got %0h exp %0h", k, out_raw, e_href ? pix : 8'h00); end
            if (e_href) pix = pix + 8'd1;
        end
    endtask

    task automatic test_shadow_load();
        logic [7:0]  pix;
        logic        e_href, e_vs;
        int          j;
        logic [31:0] rd;
        apply_reset();
        push_beats(8'h50, 8, 1'b1);
        push_beats(8'h60, 12, 1'b1);
        bus_write(A_ENABLE, 32'd1);
        pix = 8'h50;
        for (int k = 0; k < 110; k++) begin
            if (k == 20) begin
                bus_write(A_WIDTH, 32'd6);
            end else begin
                step(1'b1);
                if (k < 50) begin
                    e_href = ((k % 10) >= 6) && ((k / 10) >= 3);
                    e_vs   = ((k / 10) == 1);
                end else begin
                    j = k - 50;
                    e_href = ((j % 12) >= 6) && ((j / 12) >= 3);
                    e_vs   = ((j / 12) == 1);
                end
                if (k == 50) pix = 8'h60;
                checks++; if (out_href !== e_href) begin errors++; $display("FAIL shadow_href k=%0d got %0b exp %0b", k, out_href, e_href); end
                checks++; if (out_vsync !== e_vs) begin errors++; $display("FAIL shadow_vsync k=%0d got %0b exp %0b", k, out_vsync, e_vs); end
                checks++; if (out_raw !== (e_href ? pix : 8'h00)) begin errors++; $display("FAIL shadow_raw k=%0d got %0h exp %0h", k, out_raw, e_href ? pix : 8'h00); end
                if (e_href) pix = pix + 8'd1;
            end
        end
        bus_read(A_FRAME, rd);
        checks++; if (rd !== 32'd2) begin errors++; $display("FAIL shadow_frame_cnt got %0d exp 2", rd); end
    endtask

    task automatic test_disable_mid_line();
        logic [31:0] rd;
        apply_reset();
        push_beats(8'h70, 8, 1'b1);
        bus_write(A_ENABLE, 32'd1);
        for (int k = 0; k < 38; k++) step(1'b1);
        checks++; if (out_href !== 1'b1 || out_raw !== 8'h71) begin errors++; $display("FAIL disable_pre got href=%0b raw=%0h exp href=1 raw=71", out_href, out_raw); end
        bus_write(A_ENABLE, 32'd0);
        checks++; if (out_href !== 1'b0 || out_vsync !== 1'b0 || out_raw !== 8'h00) begin errors++; $display("FAIL disable_outputs got href=%0b vs=%0b raw=%0h exp 0", out_href, out_vsync, out_raw); end
        st_valid = 1'b1; st_sop = 1'b1; st_data = 8'h72; #1;
        checks++; if (st_ready !== 1'b0) begin errors++; $display("FAIL disable_st_ready got %0b exp 0", st_ready); end
        st_valid = 1'b0; st_sop = 1'b0;
        for (int k = 0; k < 25; k++) begin
            step(1'b1);
            checks++; if (out_href !== 1'b0 || out_vsync !== 1'b0 || out_raw !== 8'h00) begin errors++; $display("FAIL disable_idle k=%0d got href=%0b vs=%0b raw=%0h exp 0", k, out_href, out_vsync, out_raw); end
        end
        bus_read(A_FRAME, rd);
        checks++; if (rd !== 32'd1) begin errors++; $display("FAIL disable_frame_cnt got %0d exp 1", rd); end
    endtask

    task automatic test_status_race();
        logic [31:0] rd;
        apply_reset();
        bus_write(A_ENABLE, 32'd1);
        bus_read(A_STATUS, rd);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL race_status_pre got %0h exp 0", rd); end
        for (int k = 1; k < 10; k++) step(1'b0);
        // cycle 10: vs rises while software clears INT_STATUS
        bus_write(A_STATUS, 32'd0);
        as_address = A_STATUS; as_read = 1'b1; #1;
        checks++; if (as_readdata !== 32'd0) begin errors++; $display("FAIL race_read_latency got %0h exp 0", as_readdata); end
        @(posedge clk); #1;
        as_read = 1'b0;
        checks++; if (as_readdata !== 32'd1) begin errors++; $display("FAIL race_status_set_wins got %0h exp 1", as_readdata); end
        checks++; if (as_irq !== 1'b0) begin errors++; $display("FAIL race_irq_masked got %0b exp 0", as_irq); end
        bus_write(A_STATUS, 32'd0);
        bus_read(A_STATUS, rd);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL race_status_clear got %0h exp 0", rd); end
        bus_read(A_FRAME, rd);
        checks++; if (rd !== 32'd1) begin errors++; $display("FAIL race_frame_cnt got %0d exp 1", rd); end
    endtask

    initial begin
        test_reset();
        test_registers();
        test_nominal();
        test_underflow();
        test_sop_align();
        test_shadow_load();
        test_disable_mid_line();
        test_status_race();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
